// File: rtl/vector_mem_pkg.sv
// Shared types and default sizing for the vector memory unit.
// Build option VMU_STRIDE_EN enables arbitrary-stride addressing (see vmu_addr_gen).
package vector_mem_pkg;

  localparam int unsigned DefaultLanes        = 4;
  localparam int unsigned DefaultDataWidth    = 32;
  localparam int unsigned DefaultAddressWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } vmu_state_e;

endpackage

// File: rtl/vector_mem_unit_if.sv
// Request/response and data-memory port bundle for vector_mem_unit.
// master = requester + memory side, slave = the vector memory unit.
interface vector_mem_unit_if
  import vector_mem_pkg::*;
#(
  parameter int unsigned LANES         = DefaultLanes,
  parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
  parameter int unsigned ADDRESS_WIDTH = DefaultAddressWidth
);

  logic                          start;
  logic                          isStore;
  logic [ADDRESS_WIDTH-1:0]      baseAddress;
  logic [ADDRESS_WIDTH-1:0]      stride;
  logic [LANES*DATA_WIDTH-1:0]   storeVector;
  logic [LANES*DATA_WIDTH-1:0]   loadVector;
  logic                          busy;
  logic                          done;
  logic [ADDRESS_WIDTH-1:0]      memReadAddress;
  logic [ADDRESS_WIDTH-1:0]      memWriteAddress;
  logic                          memWriteEnable;
  logic [DATA_WIDTH-1:0]         memWriteData;
  logic [DATA_WIDTH-1:0]         memReadData;

  modport master (
    output start, isStore, baseAddress, stride, storeVector, memReadData,
    input  loadVector, busy, done, memReadAddress, memWriteAddress, memWriteEnable, memWriteData
  );

  modport slave (
    input  start, isStore, baseAddress, stride, storeVector, memReadData,
    output loadVector, busy, done, memReadAddress, memWriteAddress, memWriteEnable, memWriteData
  );

endinterface

// File: rtl/vmu_addr_gen.sv
// Lane counter and per-lane word address for a vector transfer.
// With VMU_STRIDE_EN the stride is latched on load; otherwise the step is fixed at 1.
module vmu_addr_gen
  import vector_mem_pkg::*;
#(
  parameter int unsigned LANES         = DefaultLanes,
  parameter int unsigned ADDRESS_WIDTH = DefaultAddressWidth
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       advance,
  input  logic [ADDRESS_WIDTH-1:0]   base,
`ifdef VMU_STRIDE_EN
  input  logic [ADDRESS_WIDTH-1:0]   stride,
`endif
  output logic [ADDRESS_WIDTH-1:0]   cur_address,
  output logic [$clog2(LANES)-1:0]   lane_index,
  output logic                       last_lane
);

  localparam int unsigned LaneW = $clog2(LANES);

  logic [ADDRESS_WIDTH-1:0] cur_q;
  logic [LaneW-1:0]         lane_q;
  logic [ADDRESS_WIDTH-1:0] next_address;

`ifdef VMU_STRIDE_EN
  logic [ADDRESS_WIDTH-1:0] stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else if (load) begin
      stride_q <= stride;
    end
  end

  assign next_address = cur_q + stride_q;
`else
  assign next_address = cur_q + ADDRESS_WIDTH'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= '0;
      lane_q <= '0;
    end else if (load) begin
      cur_q  <= base;
      lane_q <= '0;
    end else if (advance) begin
      cur_q  <= next_address;
      lane_q <= lane_q + LaneW'(1);
    end
  end

  assign cur_address = cur_q;
  assign lane_index  = lane_q;
  assign last_lane   = (lane_q == LaneW'(LANES - 1));

endmodule

// File: rtl/vector_mem_unit.sv
// Strided vector load/store engine: one lane per cycle against a single-cycle data memory.
// Build option VMU_STRIDE_EN selects strided addressing; default is unit stride.
module vector_mem_unit
  import vector_mem_pkg::*;
#(
  parameter int unsigned LANES         = DefaultLanes,
  parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
  parameter int unsigned ADDRESS_WIDTH = DefaultAddressWidth
) (
  input  logic              clk,
  input  logic              rst_n,
  vector_mem_unit_if.slave  bus
);

  vmu_state_e state_q, state_d;

  logic                                is_store_q;
  logic [LANES-1:0][DATA_WIDTH-1:0]    store_q;
  logic [LANES-1:0][DATA_WIDTH-1:0]    shadow_q, shadow_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]    load_q;
  logic [ADDRESS_WIDTH-1:0]            cur_address;
  logic [$clog2(LANES)-1:0]            lane_index;
  logic                                last_lane;
  logic                                accept;
  logic                                access;

  assign accept = (state_q == StIdle) && bus.start;
  assign access = (state_q == StAccess);

  vmu_addr_gen #(
    .LANES         (LANES),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (accept),
    .advance     (access),
    .base        (bus.baseAddress),
`ifdef VMU_STRIDE_EN
    .stride      (bus.stride),
`endif
    .cur_address (cur_address),
    .lane_index  (lane_index),
    .last_lane   (last_lane)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StAccess;
      StAccess: if (last_lane) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // The final lane is folded in combinationally so the commit holds a complete vector.
  always_comb begin
    shadow_d = shadow_q;
    if (access && !is_store_q) begin
      shadow_d[lane_index] = bus.memReadData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      is_store_q <= 1'b0;
      store_q    <= '0;
      shadow_q   <= '0;
      load_q     <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      if (accept) begin
        is_store_q <= bus.isStore;
        store_q    <= bus.storeVector;
      end
      if (access && last_lane && !is_store_q) begin
        load_q <= shadow_d;
      end
    end
  end

  assign bus.busy            = (state_q != StIdle);
  assign bus.done            = (state_q == StDone);
  assign bus.loadVector      = load_q;
  assign bus.memReadAddress  = access ? cur_address : '0;
  assign bus.memWriteAddress = access ? cur_address : '0;
  assign bus.memWriteEnable  = access && is_store_q;
  assign bus.memWriteData    = (access && is_store_q) ? store_q[lane_index] : '0;

endmodule

// File: tb/tb_vector_mem_unit.sv
// Self-checking bench for vector_mem_unit: table of transfers plus multi-cycle corner sequences.
// Expected addresses follow VMU_STRIDE_EN (strided) or unit stride when it is undefined.
module tb_vector_mem_unit;
  import vector_mem_pkg::*;

  localparam int unsigned L  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
`ifdef VMU_STRIDE_EN
  localparam bit StrideEn = 1'b1;
`else
  localparam bit StrideEn = 1'b0;
`endif

  typedef struct packed {
    logic                  is_store;
    logic [AW-1:0]         base;
    logic [AW-1:0]         stride;
    logic [L*DW-1:0]       svec;
    logic [L-1:0][AW-1:0]  exp_addr;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_mem_unit_if #(.LANES(L), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  vector_mem_unit #(.LANES(L), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  assign bus.memReadData = mem_val(bus.memReadAddress);

  int n_vec = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_wr = 0;
  int cyc = 0;
  acc_t acc_q[$];
  logic [L*DW-1:0] lv_q[$];
  logic [L*DW-1:0] exp_lv = '0;
  vec_t tv[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Monitor: pops one expected access per ACCESS cycle and one load vector per done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy && !bus.done) begin
        if (acc_q.size() == 0) begin
          flag("unexpected_access");
        end else begin
          acc_t a;
          a = acc_q.pop_front();
          check("rd_addr", 128'(bus.memReadAddress), 128'(a.addr));
          check("wr_addr", 128'(bus.memWriteAddress), 128'(a.addr));
          check("wr_en", 128'(bus.memWriteEnable), 128'(a.we));
          if (a.we) check("wr_data", 128'(bus.memWriteData), 128'(a.wdata));
        end
        if (bus.memWriteEnable) n_wr++;
      end else begin
        check("bus_quiet", 128'({bus.memReadAddress, bus.memWriteAddress, bus.memWriteData,
                                 bus.memWriteEnable}), 128'(0));
      end
      if (bus.done) begin
        n_done++;
        if (lv_q.size() == 0) flag("unexpected_done");
        else check("load_vector", 128'(bus.loadVector), 128'(lv_q.pop_front()));
      end
    end
  end

  function automatic logic [L-1:0][AW-1:0] mk4(input logic [AW-1:0] a0, a1, a2, a3);
    logic [L-1:0][AW-1:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    return r;
  endfunction

  task automatic push_exp(input vec_t v);
    for (int i = 0; i < L; i++) begin
      acc_t a;
      a.addr  = v.exp_addr[i];
      a.we    = v.is_store;
      a.wdata = v.is_store ? v.svec[i*DW +: DW] : '0;
      acc_q.push_back(a);
      if (!v.is_store) exp_lv[i*DW +: DW] = mem_val(v.exp_addr[i]);
    end
    lv_q.push_back(exp_lv);
  endtask

  task automatic drive(input vec_t v);
    bus.isStore     = v.is_store;
    bus.baseAddress = v.base;
    bus.stride      = v.stride;
    bus.storeVector = v.svec;
  endtask

  task automatic wait_done(input string name, output int at);
    at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: got no done within 30 cycles, expected done", name);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  int k, d, d2, w0, d0;
  vec_t vp;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b0, 32'd100, 32'd1, '0, mk4(100, 101, 102, 103)};
    tv[1] = '{1'b1, 32'd200, 32'd4, {32'd4, 32'd3, 32'd2, 32'd1},
              StrideEn ? mk4(200, 204, 208, 212) : mk4(200, 201, 202, 203)};
    tv[2] = '{1'b0, 32'hFFFF_FFFE, 32'd1, '0,
              mk4(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1)};
    tv[3] = '{1'b0, 32'd1000, 32'd3, '0,
              StrideEn ? mk4(1000, 1003, 1006, 1009) : mk4(1000, 1001, 1002, 1003)};
    tv[4] = '{1'b1, 32'd50, 32'hFFFF_FFFF,
              {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 32'h0BAD_F00D},
              StrideEn ? mk4(50, 49, 48, 47) : mk4(50, 51, 52, 53)};
    tv[5] = '{1'b0, 32'd7, 32'd0, '0, StrideEn ? mk4(7, 7, 7, 7) : mk4(7, 8, 9, 10)};

    bus.start = 1'b0;
    bus.isStore = 1'b0;
    bus.baseAddress = '0;
    bus.stride = '0;
    bus.storeVector = '0;

    #3;
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_done", 128'(bus.done), 128'(0));
    check("rst_load_vector", 128'(bus.loadVector), 128'(0));
    check("rst_wr_en", 128'(bus.memWriteEnable), 128'(0));
    wait_cycles(3);
    #1 rst_n = 1'b1;

    // Table-driven transfers with latency check
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      drive(tv[t]);
      push_exp(tv[t]);
      bus.start = 1'b1;
      @(posedge clk); #1;
      k = cyc;
      bus.start = 1'b0;
      wait_done("done_timeout", d);
      if (d >= 0) check("done_latency", 128'(d - k), 128'(L));
    end

    // start held high: back-to-back transfers with exactly one IDLE cycle between them
    @(posedge clk); #1;
    drive(tv[0]);
    push_exp(tv[0]);
    push_exp(tv[0]);
    bus.start = 1'b1;
    wait_done("held_done1", d);
    wait_done("held_done2", d2);
    bus.start = 1'b0;
    if (d >= 0 && d2 >= 0) check("restart_gap", 128'(d2 - d), 128'(L + 2));
    wait_cycles(6);
    check("held_no_extra", 128'(acc_q.size()), 128'(0));

    // start pulse during ACCESS must not queue a second transfer
    d0 = n_done;
    @(posedge clk); #1;
    drive(tv[3]);
    push_exp(tv[3]);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    vp = tv[2];
    drive(vp);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drive(tv[3]);
    wait_done("pulse_done", d);
    wait_cycles(8);
    check("pulse_done_count", 128'(n_done - d0), 128'(1));
    check("pulse_no_extra", 128'(acc_q.size()), 128'(0));

    // Reset after lane 1 of a store: two writes, no done, back to idle
    @(posedge clk); #1;
    drive(tv[1]);
    for (int i = 0; i < 2; i++) begin
      acc_t a;
      a.addr = tv[1].exp_addr[i];
      a.we = 1'b1;
      a.wdata = tv[1].svec[i*DW +: DW];
      acc_q.push_back(a);
    end
    w0 = n_wr;
    d0 = n_done;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_wr_en", 128'(bus.memWriteEnable), 128'(0));
    check("abort_busy", 128'(bus.busy), 128'(0));
    check("abort_writes", 128'(n_wr - w0), 128'(2));
    check("abort_load_vector", 128'(bus.loadVector), 128'(0));
    exp_lv = '0;
    wait_cycles(2);
    #1 rst_n = 1'b1;
    wait_cycles(6);
    #1;
    check("abort_no_done", 128'(n_done - d0), 128'(0));
    check("abort_idle", 128'(bus.busy), 128'(0));
    check("abort_queue", 128'(acc_q.size()), 128'(0));

    // Recovery load after the aborted store
    @(posedge clk); #1;
    drive(tv[2]);
    push_exp(tv[2]);
    bus.start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    bus.start = 1'b0;
    wait_done("recover_done", d);
    if (d >= 0) check("recover_latency", 128'(d - k), 128'(L));
    wait_cycles(2);
    check("final_acc_queue", 128'(acc_q.size()), 128'(0));
    check("final_lv_queue", 128'(lv_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_mem_unit.md
VECTOR_MEM_UNIT -- requirements
Module: vector_mem_unit

Interface
REQ-001 Parameter LANES, default 4, number of lanes per vector transfer (power of two, 2..16).
REQ-002 Parameter DATA_WIDTH, default 32, width of one memory word and one lane.
REQ-003 Parameter ADDRESS_WIDTH, default 32, width of word addresses.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock, shared with the data memory.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request a vector transfer; sampled only in IDLE.
REQ-008 isStore  input  1  1 = vector store, 0 = vector load; latched with start.
REQ-009 baseAddress  input  ADDRESS_WIDTH  word address of lane 0; latched with start.
REQ-010 stride  input  ADDRESS_WIDTH  word distance between lanes; latched with start.
REQ-011 storeVector  input  LANES*DATA_WIDTH  store data, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]; latched with start.
REQ-012 loadVector  output  LANES*DATA_WIDTH  last completed load result, same lane packing.
REQ-013 busy  output  1  high in ACCESS and DONE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 memReadAddress / memWriteAddress  output  ADDRESS_WIDTH  drive the data memory's read and write ports.
REQ-016 memWriteEnable  output  1  memory write strobe.
REQ-017 memWriteData  output  DATA_WIDTH  memory write data.
REQ-018 memReadData  input  DATA_WIDTH  combinational read data from the memory, valid in the same cycle as memReadAddress.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS and DONE: IDLE->ACCESS on start; ACCESS->DONE after lane LANES-1; DONE->IDLE unconditionally.
REQ-020 On start in IDLE, the block SHALL latch isStore, baseAddress, stride and storeVector, and set laneIndex=0 and curAddress=baseAddress.
REQ-021 In ACCESS, one lane per cycle: both memory address outputs SHALL equal curAddress; curAddress SHALL advance by stride each cycle, modulo 2^ADDRESS_WIDTH.
REQ-022 For a load in ACCESS, memReadData SHALL be captured into shadow lane laneIndex at the clock edge; memWriteEnable SHALL stay 0.
REQ-023 For a store in ACCESS, memWriteEnable SHALL be 1 and memWriteData SHALL be latched lane laneIndex.
REQ-024 On entry to DONE after a load, the full shadow SHALL be committed to loadVector in one edge; partial results SHALL never appear on loadVector.
REQ-025 A store SHALL leave loadVector unchanged.
REQ-026 done SHALL be 1 only in DONE; start sampled at edge k SHALL give done high in the cycle after edge k+LANES.
REQ-027 start outside IDLE SHALL be ignored, with no queuing.
REQ-028 Outside ACCESS, memWriteEnable, memWriteData and both address outputs SHALL be 0.
REQ-029 A start asserted in the DONE cycle SHALL be ignored; the earliest accepted restart is in the following IDLE cycle.

Reset
REQ-030 While rst_n=0, the block SHALL asynchronously go to IDLE and clear loadVector, the shadow, laneIndex, curAddress, busy, done and memWriteEnable.
REQ-031 Reset in mid-operation SHALL abort the transfer; lanes already written stay in memory, and no done pulse is issued.

Configuration
REQ-032 Macro VMU_STRIDE_EN: when defined, the latched stride SHALL be used; when undefined, the stride port SHALL be ignored and stride SHALL be fixed at 1 (unit-stride only, with a stride-free adder).

Structure
REQ-033 Package vector_mem_pkg SHALL hold the state enum (IDLE, ACCESS, DONE) and the default LANES, DATA_WIDTH and ADDRESS_WIDTH constants.
REQ-034 Sub-module vmu_addr_gen SHALL hold curAddress and laneIndex with load, advance and last-lane outputs; the FSM and data path stay in vector_mem_unit.

Verification
REQ-035 Load, base=100, stride=1, memory[100..103]=A,B,C,D: addresses 100,101,102,103 on four consecutive cycles; done 5 cycles after start; loadVector={D,C,B,A}.
REQ-036 Store, base=200, stride=4, lanes {4,3,2,1} (VMU_STRIDE_EN defined): writes 1@200, 2@204, 3@208, 4@212; loadVector unchanged.
REQ-037 Same store with VMU_STRIDE_EN undefined: writes to 200..203.
REQ-038 Load, base=0xFFFFFFFE, stride=1: addresses FFFFFFFE, FFFFFFFF, 0, 1 (wrap-around).
REQ-039 start held high continuously: transfers separated by one IDLE cycle; start pulse during ACCESS is ignored.
REQ-040 rst_n low after lane 1 of a store: memWriteEnable drops 0 immediately, only lanes 0-1 written, no done, IDLE after release.
